// File: rtl/fen_loader_pkg.sv
// Shared definitions for the FEN loader and the board/FEN conversion stages:
// piece codes, castle bit positions, parser states and control characters.
package fen_loader_pkg;

  localparam int DEFAULT_PIECE_WIDTH = 4;
  localparam int DEFAULT_ROW_WIDTH   = 8 * DEFAULT_PIECE_WIDTH;
  localparam int DEFAULT_BOARD_WIDTH = 64 * DEFAULT_PIECE_WIDTH;

  typedef logic [3:0] piece_t;

  localparam piece_t EMPTY        = 4'd0;
  localparam piece_t WHITE_PAWN   = 4'd1;
  localparam piece_t WHITE_ROOK   = 4'd2;
  localparam piece_t WHITE_KNIGHT = 4'd3;
  localparam piece_t WHITE_BISHOP = 4'd4;
  localparam piece_t WHITE_KING   = 4'd5;
  localparam piece_t WHITE_QUEN   = 4'd6;
  localparam piece_t BLACK_PAWN   = 4'd7;
  localparam piece_t BLACK_ROOK   = 4'd8;
  localparam piece_t BLACK_KNIGHT = 4'd9;
  localparam piece_t BLACK_BISHOP = 4'd10;
  localparam piece_t BLACK_KING   = 4'd11;
  localparam piece_t BLACK_QUEN   = 4'd12;

  localparam int CASTLE_WK = 0;
  localparam int CASTLE_WQ = 1;
  localparam int CASTLE_BK = 2;
  localparam int CASTLE_BQ = 3;

  localparam logic [7:0] CH_LF    = 8'h0a;
  localparam logic [7:0] CH_CR    = 8'h0d;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_DASH  = 8'h2d;
  localparam logic [7:0] CH_SLASH = 8'h2f;

  typedef enum logic [2:0] {
    ST_PLACE,
    ST_SIDE,
    ST_SEP,
    ST_CASTLE,
    ST_SKIP,
    ST_DONE,
    ST_ERR_SKIP
  } fen_state_t;

endpackage

// File: rtl/fen_loader_if.sv
// Character-stream input and published-position output of the FEN loader.
interface fen_loader_if #(
  parameter int BOARD_WIDTH = fen_loader_pkg::DEFAULT_BOARD_WIDTH
);
  logic [7:0]             in_char;
  logic                   in_valid;
  logic                   in_ready;
  logic [BOARD_WIDTH-1:0] board;
  logic                   white_to_move;
  logic [3:0]             castle_mask;
  logic                   board_valid;
  logic                   parse_error;

  modport master (
    output in_char, in_valid,
    input  in_ready, board, white_to_move, castle_mask, board_valid, parse_error
  );

  modport slave (
    input  in_char, in_valid,
    output in_ready, board, white_to_move, castle_mask, board_valid, parse_error
  );
endinterface

// File: rtl/fen_char_decode.sv
// Combinational FEN character classifier: piece letters and placement digits.
module fen_char_decode
  import fen_loader_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       is_piece,
  output piece_t     piece_code,
  output logic       is_digit,
  output logic [3:0] digit_value
);

  always_comb begin
    is_piece   = 1'b1;
    piece_code = EMPTY;
    case (ascii)
      "P": piece_code = WHITE_PAWN;
      "R": piece_code = WHITE_ROOK;
      "N": piece_code = WHITE_KNIGHT;
      "B": piece_code = WHITE_BISHOP;
      "K": piece_code = WHITE_KING;
      "Q": piece_code = WHITE_QUEN;
      "p": piece_code = BLACK_PAWN;
      "r": piece_code = BLACK_ROOK;
      "n": piece_code = BLACK_KNIGHT;
      "b": piece_code = BLACK_BISHOP;
      "k": piece_code = BLACK_KING;
      "q": piece_code = BLACK_QUEN;
      default: is_piece = 1'b0;
    endcase
  end

  // Only '1'..'8' are legal run lengths; '0' and '9' fall through as errors.
  assign is_digit    = (ascii >= "1") && (ascii <= "8");
  assign digit_value = is_digit ? ascii[3:0] : 4'd0;

endmodule

// File: rtl/fen_loader.sv
// Parses a FEN character stream into a packed board, side to move and castling
// rights; publishes only complete, well-formed lines.
//
// state       | meaning
// ST_PLACE    | piece placement field, rank 8 down to rank 1
// ST_SIDE     | expecting 'w' or 'b'
// ST_SEP      | after side: ' ' to castling field, '\n' ends line
// ST_CASTLE   | castling field ('-' or KQkq)
// ST_SKIP     | en-passant and move counters, discarded until '\n'
// ST_DONE     | one cycle: publish working copy, not ready
// ST_ERR_SKIP | rejected line, discard until '\n'
module fen_loader
  import fen_loader_pkg::*;
#(
  parameter int PIECE_WIDTH = DEFAULT_PIECE_WIDTH,
  parameter int ROW_WIDTH   = DEFAULT_ROW_WIDTH,
  parameter int BOARD_WIDTH = DEFAULT_BOARD_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  fen_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(BOARD_WIDTH);

  fen_state_t             state_q;
  logic [BOARD_WIDTH-1:0] work_board;
  logic [2:0]             rank_q;
  logic [3:0]             file_q;
  logic                   side_q;
  logic [3:0]             castle_q;

  logic       is_piece, is_digit;
  piece_t     piece_code;
  logic [3:0] digit_value;

  logic             accept, char_err, restart, is_lf, is_sp, file_full;
  logic [4:0]       file_sum;
  logic [IDX_W-1:0] sq_base;

  fen_char_decode u_decode (
    .ascii       (bus.in_char),
    .is_piece    (is_piece),
    .piece_code  (piece_code),
    .is_digit    (is_digit),
    .digit_value (digit_value)
  );

  assign bus.in_ready = (state_q != ST_DONE);

  // Carriage returns complete a handshake but never reach the parser.
  assign accept    = bus.in_valid && bus.in_ready && (bus.in_char != CH_CR);
  assign is_lf     = (bus.in_char == CH_LF);
  assign is_sp     = (bus.in_char == CH_SP);
  assign file_full = (file_q == 4'd8);
  assign file_sum  = {1'b0, file_q} + {1'b0, digit_value};
  assign sq_base   = IDX_W'(int'(rank_q) * ROW_WIDTH + int'(file_q[2:0]) * PIECE_WIDTH);

  always_comb begin
    char_err = 1'b0;
    case (state_q)
      ST_PLACE: begin
        if (is_piece)                      char_err = file_q[3];
        else if (is_digit)                 char_err = (file_sum > 5'd8);
        else if (bus.in_char == CH_SLASH)  char_err = !(file_full && (rank_q != 3'd0));
        else if (is_sp)                    char_err = !(file_full && (rank_q == 3'd0));
        else                               char_err = 1'b1;
      end
      ST_SIDE:   char_err = !((bus.in_char == "w") || (bus.in_char == "b"));
      ST_SEP:    char_err = !(is_sp || is_lf);
      ST_CASTLE: char_err = !(is_sp || is_lf || (bus.in_char == CH_DASH) ||
                              (bus.in_char == "K") || (bus.in_char == "Q") ||
                              (bus.in_char == "k") || (bus.in_char == "q"));
      default:   char_err = 1'b0;
    endcase
  end

  assign restart = (state_q == ST_DONE) ||
                   (accept && is_lf && (char_err || (state_q == ST_ERR_SKIP)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= ST_PLACE;
      work_board        <= '0;
      rank_q            <= 3'd7;
      file_q            <= 4'd0;
      side_q            <= 1'b1;
      castle_q          <= 4'd0;
      bus.board         <= '0;
      bus.white_to_move <= 1'b1;
      bus.castle_mask   <= 4'd0;
      bus.board_valid   <= 1'b0;
      bus.parse_error   <= 1'b0;
    end else begin
      bus.board_valid <= 1'b0;
      bus.parse_error <= accept && char_err;

      if (state_q == ST_DONE) begin
        bus.board         <= work_board;
        bus.white_to_move <= side_q;
        bus.castle_mask   <= castle_q;
        bus.board_valid   <= 1'b1;
      end

      if (restart) begin
        state_q    <= ST_PLACE;
        work_board <= '0;
        rank_q     <= 3'd7;
        file_q     <= 4'd0;
        side_q     <= 1'b1;
        castle_q   <= 4'd0;
      end else if (accept && char_err) begin
        state_q <= ST_ERR_SKIP;
      end else if (accept) begin
        case (state_q)
          ST_PLACE: begin
            if (is_piece) begin
              work_board[sq_base +: PIECE_WIDTH] <= PIECE_WIDTH'(piece_code);
              file_q <= file_q + 4'd1;
            end else if (is_digit) begin
              file_q <= file_sum[3:0];
            end else if (bus.in_char == CH_SLASH) begin
              rank_q <= rank_q - 3'd1;
              file_q <= 4'd0;
            end else begin
              state_q <= ST_SIDE;
            end
          end
          ST_SIDE: begin
            side_q  <= (bus.in_char == "w");
            state_q <= ST_SEP;
          end
          ST_SEP:
            state_q <= is_lf ? ST_DONE : ST_CASTLE;
          ST_CASTLE: begin
            case (bus.in_char)
              "K":     castle_q[CASTLE_WK] <= 1'b1;
              "Q":     castle_q[CASTLE_WQ] <= 1'b1;
              "k":     castle_q[CASTLE_BK] <= 1'b1;
              "q":     castle_q[CASTLE_BQ] <= 1'b1;
              CH_SP:   state_q <= ST_SKIP;
              CH_LF:   state_q <= ST_DONE;
              default: ;
            endcase
          end
          ST_SKIP:
            if (is_lf) state_q <= ST_DONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fen_loader.sv
// Directed bench for fen_loader: known FEN lines, malformed lines, gaps/CRLF,
// back-to-back lines and a mid-line reset, checked against hand-built boards.
module tb_fen_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fen_loader_if #(.BOARD_WIDTH(256)) bus ();

  fen_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int bv_cnt = 0, pe_cnt = 0, rdy_lo_cnt = 0;
  int bv_cycle = -1, pe_cycle = -1;
  int last_hs = -1, mark_cycle = -1;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.board_valid) begin
        bv_cnt   <= bv_cnt + 1;
        bv_cycle <= cycle;
      end
      if (bus.parse_error) begin
        pe_cnt   <= pe_cnt + 1;
        pe_cycle <= cycle;
      end
      if (!bus.in_ready) rdy_lo_cnt <= rdy_lo_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_char(input byte c);
    int n;
    n = 0;
    bus.in_char  = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $error("FAIL ready_timeout observed=0 expected=1");
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    last_hs = cycle;
  endtask

  task automatic send_line(input string s, input bit gaps, input int mark_idx, input bit idle);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_char(s[i]);
      if (i == mark_idx) mark_cycle = last_hs;
    end
    bus.in_valid = 1'b0;
    if (idle) begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int r, input int f,
                                       input logic [3:0] c);
    b[r*32 + f*4 +: 4] = c;
    return b;
  endfunction

  function automatic logic [3:0] sq(input logic [255:0] b, input int r, input int f);
    return b[r*32 + f*4 +: 4];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  string start_fen;
  string kings_fen;
  logic [255:0] exp_start, exp_kings, exp_castle;
  int back_w[8] = '{2, 3, 4, 6, 5, 4, 3, 2};
  int back_b[8] = '{8, 9, 10, 12, 11, 10, 9, 8};
  int bv0, pe0, rl0;

  initial begin
    start_fen = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1\n";
    kings_fen = "8/8/8/8/8/8/8/4K2k b - - 0 1\n";
    exp_start = '0;
    for (int f = 0; f < 8; f++) begin
      exp_start = put(exp_start, 0, f, 4'(back_w[f]));
      exp_start = put(exp_start, 1, f, 4'd1);
      exp_start = put(exp_start, 6, f, 4'd7);
      exp_start = put(exp_start, 7, f, 4'(back_b[f]));
    end
    exp_kings = put(put(256'd0, 0, 4, 4'd5), 0, 7, 4'd11);
    exp_castle = '0;
    exp_castle = put(exp_castle, 7, 0, 4'd8);
    exp_castle = put(exp_castle, 7, 4, 4'd11);
    exp_castle = put(exp_castle, 7, 7, 4'd8);
    exp_castle = put(exp_castle, 0, 0, 4'd2);
    exp_castle = put(exp_castle, 0, 4, 4'd5);
    exp_castle = put(exp_castle, 0, 7, 4'd2);

    bus.in_char  = 8'h00;
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_board", bus.board, 256'd0);
    check("reset_wtm", 256'(bus.white_to_move), 256'd1);
    check("reset_castle", 256'(bus.castle_mask), 256'd0);
    check("reset_bv", 256'(bus.board_valid), 256'd0);
    check("reset_pe", 256'(bus.parse_error), 256'd0);
    check("reset_ready", 256'(bus.in_ready), 256'd1);
    @(posedge clk);
    #1;

    // Start position, gap-free
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line(start_fen, 1'b0, start_fen.len() - 1, 1'b1);
    check("start_bv_count", 256'(bv_cnt - bv0), 256'd1);
    check("start_bv_timing", 256'(bv_cycle), 256'(mark_cycle + 1));
    check("start_pe_count", 256'(pe_cnt - pe0), 256'd0);
    check("start_a8", 256'(sq(bus.board, 7, 0)), 256'd8);
    check("start_e1", 256'(sq(bus.board, 0, 4)), 256'd5);
    check("start_rank3", 256'(bus.board[3*32 +: 32]), 256'd0);
    check("start_board", bus.board, exp_start);
    check("start_wtm", 256'(bus.white_to_move), 256'd1);
    check("start_castle", 256'(bus.castle_mask), 256'hf);

    bv0 = bv_cnt;
    send_line(kings_fen, 1'b0, -1, 1'b1);
    check("kings_bv_count", 256'(bv_cnt - bv0), 256'd1);
    check("kings_board", bus.board, exp_kings);
    check("kings_wtm", 256'(bus.white_to_move), 256'd0);
    check("kings_castle", 256'(bus.castle_mask), 256'd0);

    // Bad digit as the very first char
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line("9/8/8/8/8/8/8/8 w - - 0 1\n", 1'b0, 0, 1'b1);
    check("nine_pe_count", 256'(pe_cnt - pe0), 256'd1);
    check("nine_pe_timing", 256'(pe_cycle), 256'(mark_cycle));
    check("nine_bv_count", 256'(bv_cnt - bv0), 256'd0);
    check("nine_board_kept", bus.board, exp_kings);
    check("nine_wtm_kept", 256'(bus.white_to_move), 256'd0);

    // Ninth piece on a full rank
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line("ppppppppp/8/8/8/8/8/8/8 w - - 0 1\n", 1'b0, 8, 1'b1);
    check("ninep_pe_count", 256'(pe_cnt - pe0), 256'd1);
    check("ninep_pe_timing", 256'(pe_cycle), 256'(mark_cycle));
    check("ninep_bv_count", 256'(bv_cnt - bv0), 256'd0);
    check("ninep_board_kept", bus.board, exp_kings);

    // Start position with random gaps and CRLF ending
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1\r\n", 1'b1, -1, 1'b1);
    check("gaps_bv_count", 256'(bv_cnt - bv0), 256'd1);
    check("gaps_pe_count", 256'(pe_cnt - pe0), 256'd0);
    check("gaps_board", bus.board, exp_start);
    check("gaps_wtm", 256'(bus.white_to_move), 256'd1);
    check("gaps_castle", 256'(bus.castle_mask), 256'hf);

    // Short line, newline is the offending char
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line("8/8/8\n", 1'b0, 5, 1'b1);
    check("short_pe_count", 256'(pe_cnt - pe0), 256'd1);
    check("short_pe_timing", 256'(pe_cycle), 256'(mark_cycle));
    check("short_bv_count", 256'(bv_cnt - bv0), 256'd0);
    check("short_board_kept", bus.board, exp_start);

    bv0 = bv_cnt;
    send_line("r3k2r/8/8/8/8/8/8/R3K2R w Kq -\n", 1'b0, -1, 1'b1);
    check("castle_bv_count", 256'(bv_cnt - bv0), 256'd1);
    check("castle_board", bus.board, exp_castle);
    check("castle_mask_kq", 256'(bus.castle_mask), 256'h9);

    // Back-to-back lines; the second ends straight after the side field
    bv0 = bv_cnt; rl0 = rdy_lo_cnt; pe0 = pe_cnt;
    send_line(kings_fen, 1'b0, -1, 1'b0);
    send_line("8/8/8/8/8/8/8/8 b\n", 1'b0, -1, 1'b1);
    check("b2b_bv_count", 256'(bv_cnt - bv0), 256'd2);
    check("b2b_ready_low", 256'(rdy_lo_cnt - rl0), 256'd2);
    check("b2b_pe_count", 256'(pe_cnt - pe0), 256'd0);
    check("b2b_board", bus.board, 256'd0);
    check("b2b_wtm", 256'(bus.white_to_move), 256'd0);
    check("b2b_castle", 256'(bus.castle_mask), 256'd0);

    // Load a board, then reset part-way through the next line
    send_line(start_fen, 1'b0, -1, 1'b1);
    send_line(start_fen.substr(0, 19), 1'b0, -1, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_board", bus.board, 256'd0);
    check("midrst_wtm", 256'(bus.white_to_move), 256'd1);
    check("midrst_castle", 256'(bus.castle_mask), 256'd0);
    check("midrst_bv", 256'(bus.board_valid), 256'd0);
    @(posedge clk);
    #1;
    bv0 = bv_cnt; pe0 = pe_cnt;
    send_line(start_fen, 1'b0, -1, 1'b1);
    check("postrst_bv_count", 256'(bv_cnt - bv0), 256'd1);
    check("postrst_pe_count", 256'(pe_cnt - pe0), 256'd0);
    check("postrst_board", bus.board, exp_start);
    check("postrst_castle", 256'(bus.castle_mask), 256'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fen_loader.md
Name: fen_loader

Overview:
- Upstream stage of the board display/search path: parses a Forsyth-Edwards Notation (FEN) ASCII character stream into the packed board vector.
- Consumes one character per valid/ready handshake; captures side-to-move and castling rights.
- Emits a one-cycle board_valid pulse that drives the display stage's display input directly.
- Malformed lines are rejected with parse_error; the previously published board is left untouched.

Parameters:
PIECE_WIDTH, 4, bits per square; piece codes from shared defines, 0 = empty
ROW_WIDTH, 32, bits per rank; must equal 8*PIECE_WIDTH
BOARD_WIDTH, 256, bits per board; must equal 64*PIECE_WIDTH

Ports:
clk  in  1  clock
reset_n  in  1  reset: one clock, synchronous, active-low
in_char  in  8  ASCII character
in_valid  in  1  in_char valid
in_ready  out  1  loader accepts in_char this cycle
board  out  BOARD_WIDTH  last successfully parsed board
white_to_move  out  1  1 = white to move
castle_mask  out  4  bit0 K, bit1 Q, bit2 k, bit3 q
board_valid  out  1  one-cycle pulse: new board published
parse_error  out  1  one-cycle pulse: current line rejected

Behaviour:
- Square layout: square (rank r 0..7, file f 0..7) sits at bit index r*ROW_WIDTH + f*PIECE_WIDTH. a1 is index 0; a8 is 7*ROW_WIDTH.
- Char accepted only when in_valid && in_ready. '\r' is accepted and ignored in every state.
- Reset (reset_n=0 at clk edge), which also aborts any line mid-parse:
  - Outputs: board=0, white_to_move=1, castle_mask=0, board_valid=0, parse_error=0.
  - Internal: working board=0, rank=7, file=0, state=PLACE.
- in_ready=1 in all states except DONE.
- PLACE state:
  - Piece letter PRNBKQprnbkq with file<8: write code into working board at (rank,file); file++.
  - Digit 1-8: file += n. If file+n>8, error. Skipped squares stay 0; working board is cleared at line start.
  - '/': requires file==8 and rank>0; then rank--, file=0.
  - ' ': requires rank==0 and file==8; then go to SIDE.
  - Anything else, or '/'/' ' failing its check, is an error.
- SIDE state:
  - 'w'/'b' sets the working side flag, then go to SEP.
- SEP state:
  - ' ' goes to CASTLE.
  - '\n' goes to DONE with castle=0.
  - Other chars are an error.
- CASTLE state:
  - '-' leaves castle=0.
  - K/Q/k/q set their bit; repeats are harmless.
  - ' ' goes to SKIP.
  - '\n' goes to DONE.
  - Other chars are an error.
- SKIP state: en-passant field and move counters are discarded unchecked until '\n', then go to DONE.
- DONE state (exactly one cycle):
  - board, white_to_move, castle_mask are loaded from the working copy; board_valid=1; in_ready=0.
  - Working state is reinitialised (board 0, rank 7, file 0, castle 0, side white); next state is PLACE.
  - board_valid therefore rises the cycle after the terminating '\n' handshake.
- Error handling:
  - parse_error=1 for the cycle after the offending char handshake.
  - If the offending char is '\n', reinitialise and return to PLACE. Otherwise go to ERR_SKIP, which discards until '\n', then reinitialises and returns to PLACE.
  - No board_valid is produced for a rejected line; published outputs do not change.
- Outputs are registered; the published board is stable between board_valid pulses.
- Counters: rank is 3 bits; file is 4 bits so that 8 is representable.

Decomposition:
- Shared defines/package holds:
  - piece codes WHITE_PAWN..BLACK_QUEN, EMPTY=0, PIECE_WIDTH/ROW_WIDTH/BOARD_WIDTH defaults;
  - castle bit indices CASTLE_WK/WQ/BK/BQ.
- Natural sub-module: fen_char_decode, combinational.
  - Input: ASCII.
  - Outputs: is_piece, piece_code, is_digit, digit_value.
  - Shared later with a board-to-FEN writer.

Test Plan:
- Start FEN "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1\n", in_valid held high:
  - exactly one board_valid, the cycle after '\n';
  - square at 7*ROW_WIDTH = BLACK_ROOK; square at 4*PIECE_WIDTH = WHITE_KING; rank 3 all zero;
  - white_to_move=1; castle_mask=4'b1111.
- "8/8/8/8/8/8/8/4K2k b - - 0 1\n" -> white_to_move=0, castle_mask=0, only e1=WHITE_KING and h1=BLACK_KING nonzero.
- Error "9/..." or "ppppppppp/..." -> parse_error pulse at offending char; no board_valid; board unchanged from prior load. The following valid line loads normally.
- Short line "8/8/8\n" -> parse_error; next line parses; back-to-back lines produce in_ready=0 for exactly one cycle per DONE.
- Random in_valid gaps plus "\r\n" endings -> result identical to gap-free stimulus.
- reset_n=0 mid-line (after 20 chars) -> all outputs return to reset values; a fresh full FEN then loads correctly.
